// File: rtl/approx_mult_pipe.sv
// ---------------------------------------------------------------------------
// approx_mult_pipe
//   Pipelined W x W unsigned approximate multiplier. Operands are split into
//   four H x H quadrant sub-products (H = W/2). Each sub-product has its low
//   bits truncated under a per-quadrant 2-bit mode. The four sub-products are
//   recombined with a lower-part-OR adder: the low LOA_BITS bits are ORed and
//   the upper bits are summed with no carry in from the low part.
//
//   Pipeline: S1 capture -> S2 quadrant products -> S3 recombine/output.
//   A single global advance (adv = !out_valid || out_ready) moves every stage.
//   Bubbles are not collapsed.
//
//   Optional macro APPROX_MULT_ERR_MON_EN adds an exact shadow product with
//   an error output (err = exact - r) and a saturating 16-bit count of
//   completed beats whose err is nonzero.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid          in_ready  beat accepted this cycle
//   a, b       W-bit unsigned operands     mode      2 bits per quadrant
//                                                    [1:0]LL [3:2]LH [5:4]HL [7:6]HH
//   out_valid  result valid                out_ready downstream accepts
//   r          2W-bit approximate product
//   err        (macro) exact - r, valid with out_valid
//   err_cnt    (macro) saturating count of completed beats with err != 0
// ---------------------------------------------------------------------------
module approx_mult_pipe #(
    parameter int W          = 8,
    parameter int TRUNC_STEP = 1,
    parameter int LOA_BITS   = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [7:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] r
`ifdef APPROX_MULT_ERR_MON_EN
    ,
    output logic [2*W-1:0] err,
    output logic [15:0]    err_cnt
`endif
);

    localparam int H  = W / 2;
    localparam int RW = 2 * W;

    // Clears the low min(TRUNC_STEP*m, W) bits of a sub-product.
    function automatic logic [W-1:0] trunc(input logic [W-1:0] p, input logic [1:0] m);
        logic [W-1:0] res;
        int           n;
        n = TRUNC_STEP * int'(m);
        if (n > W) n = W;
        for (int i = 0; i < W; i++) res[i] = (i >= n) ? p[i] : 1'b0;
        return res;
    endfunction

    // Mask selecting the OR-combined low part of the result.
    function automatic logic [RW-1:0] lo_mask();
        logic [RW-1:0] m;
        for (int i = 0; i < RW; i++) m[i] = (i < LOA_BITS);
        return m;
    endfunction

    localparam logic [RW-1:0] LO_MASK = lo_mask();

    logic adv;

    // Stage valid bits: [0] S1, [1] S2, [2] S3 (= out_valid).
    logic [2:0] vld_q;

    // S1 registers
    logic [W-1:0] a_q, b_q;
    logic [7:0]   mode_q;

    // S2 registers (quadrant sub-products)
    logic [W-1:0] ll_q, lh_q, hl_q, hh_q;
    logic [W-1:0] ll_d, lh_d, hl_d, hh_d;

    // S3 registers
    logic [RW-1:0] r_q, r_d;

    assign adv       = !vld_q[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[2];
    assign r         = r_q;

    // S2 combinational: exact H x H products widened to W, then truncated.
    always_comb begin
        ll_d = trunc(W'(a_q[H-1:0]) * W'(b_q[H-1:0]), mode_q[1:0]);
        lh_d = trunc(W'(a_q[H-1:0]) * W'(b_q[W-1:H]), mode_q[3:2]);
        hl_d = trunc(W'(a_q[W-1:H]) * W'(b_q[H-1:0]), mode_q[5:4]);
        hh_d = trunc(W'(a_q[W-1:H]) * W'(b_q[W-1:H]), mode_q[7:6]);
    end

    // S3 combinational: lower-part-OR recombination. The upper sum is formed
    // from the contributions pre-shifted right, so no carry leaks up from the
    // ORed low bits; shifting back left drops anything beyond 2W bits.
    logic [RW-1:0] c0, c1, c2, c3, low_or, hi_sum;
    always_comb begin
        c0     = RW'(ll_q);
        c1     = RW'(lh_q) << H;
        c2     = RW'(hl_q) << H;
        c3     = RW'(hh_q) << W;
        low_or = (c0 | c1 | c2 | c3) & LO_MASK;
        hi_sum = (c0 >> LOA_BITS) + (c1 >> LOA_BITS)
               + (c2 >> LOA_BITS) + (c3 >> LOA_BITS);
        r_d    = (hi_sum << LOA_BITS) | low_or;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
            ll_q   <= '0;
            lh_q   <= '0;
            hl_q   <= '0;
            hh_q   <= '0;
            r_q    <= '0;
        end else if (adv) begin
            vld_q  <= {vld_q[1:0], in_valid};
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            ll_q   <= ll_d;
            lh_q   <= lh_d;
            hl_q   <= hl_d;
            hh_q   <= hh_d;
            r_q    <= r_d;
        end
    end

`ifdef APPROX_MULT_ERR_MON_EN
    // Exact shadow product rides alongside S2; the error is formed against
    // the S3 result as it is registered so both are valid together.
    logic [RW-1:0] exact_q, err_q;
    logic [15:0]   err_cnt_q;

    assign err     = err_q;
    assign err_cnt = err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            exact_q   <= '0;
            err_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            if (adv) begin
                exact_q <= RW'(a_q) * RW'(b_q);
                err_q   <= exact_q - r_d;
            end
            if (vld_q[2] && out_ready && (err_q != '0) && (err_cnt_q != 16'hFFFF))
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_approx_mult_pipe
//   Two instances share all inputs: dut uses the default parameters
//   (LOA_BITS = 6), dut_x uses LOA_BITS = 0 (exact adder). Inputs change
//   1 time unit after the rising edge; outputs and handshakes are sampled on
//   the falling edge. Expected results come from ref_mult, which applies the
//   quadrant/truncation/OR-adder rules with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_approx_mult_pipe;

    localparam int W  = 8;
    localparam int TS = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, out_ready;
    logic [W-1:0]  a, b;
    logic [7:0]    mode;
    logic          in_ready, out_valid, in_ready_x, out_valid_x;
    logic [2*W-1:0] r, r_x;
`ifdef APPROX_MULT_ERR_MON_EN
    logic [2*W-1:0] err, err_x;
    logic [15:0]    err_cnt, err_cnt_x;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Result of the most recent run_beat
    logic [2*W-1:0] obs_r, obs_rx;
    int             obs_lat;
`ifdef APPROX_MULT_ERR_MON_EN
    logic [2*W-1:0] obs_err;
`endif

    always #5 clk = ~clk;

    approx_mult_pipe #(.W(W), .TRUNC_STEP(TS), .LOA_BITS(6)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .r(r)
`ifdef APPROX_MULT_ERR_MON_EN
        , .err(err), .err_cnt(err_cnt)
`endif
    );

    approx_mult_pipe #(.W(W), .TRUNC_STEP(TS), .LOA_BITS(0)) dut_x (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_x),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid_x), .out_ready(out_ready), .r(r_x)
`ifdef APPROX_MULT_ERR_MON_EN
        , .err(err_x), .err_cnt(err_cnt_x)
`endif
    );

    // Reference: quadrant products, low-bit truncation, then OR the low `loa`
    // bits of the shifted contributions and add their upper parts.
    function automatic longint unsigned ref_mult(input int unsigned aa, input int unsigned bb,
                                                 input int unsigned md, input int loa);
        longint unsigned base, q[4], c, lowor, hi, res;
        int sh[4];
        int n;
        base = 64'd1 << (W / 2);
        q[0] = (aa % base) * (bb % base);
        q[1] = (aa % base) * (bb / base);
        q[2] = (aa / base) * (bb % base);
        q[3] = (aa / base) * (bb / base);
        sh   = '{0, W / 2, W / 2, W};
        lowor = 0;
        hi    = 0;
        for (int k = 0; k < 4; k++) begin
            n = int'((md >> (2 * k)) & 3) * TS;
            if (n > W) n = W;
            q[k]  = (q[k] >> n) << n;
            c     = q[k] << sh[k];
            lowor = lowor | (c % (64'd1 << loa));
            hi    = hi + (c >> loa);
        end
        res = ((hi << loa) + lowor) % (64'd1 << (2 * W));
        return res;
    endfunction

    // Present one beat with out_ready = 1 and wait for its result.
    // Starts and ends 1 unit after a rising edge.
    task automatic run_beat(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [7:0] im);
        bit got;
        a = ia; b = ib; mode = im; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 0;
        obs_lat = -1;
        obs_r = '0;
        obs_rx = '0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1; obs_lat = i; obs_r = r; obs_rx = r_x;
`ifdef APPROX_MULT_ERR_MON_EN
                obs_err = err;
`endif
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || r !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: out_valid=%b r=%h in_ready=%b, need 0/0000/1", out_valid, r, in_ready);
        end
`ifdef APPROX_MULT_ERR_MON_EN
        n_checks++;
        if (err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_errcnt: got %h need 0000", err_cnt);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_exact();
        run_beat(8'hFF, 8'hFF, 8'h00);
        n_checks++;
        if (obs_lat !== 3) begin
            n_fail++;
            $display("FAIL exact_latency: got %0d need 3", obs_lat);
        end
        n_checks++;
        if (obs_rx !== 16'hFE01) begin
            n_fail++;
            $display("FAIL exact_r: got %h need FE01", obs_rx);
        end
        n_checks++;
        if (obs_r !== 16'(ref_mult(8'hFF, 8'hFF, 0, 6))) begin
            n_fail++;
            $display("FAIL exact_loa_r: got %h need %h", obs_r, 16'(ref_mult(8'hFF, 8'hFF, 0, 6)));
        end
    endtask

    task automatic test_loa();
`ifdef APPROX_MULT_ERR_MON_EN
        logic [15:0] cnt0;
        cnt0 = err_cnt;
`endif
        run_beat(8'h1F, 8'h11, 8'h00);
        n_checks++;
        if (obs_r !== 16'h01FF) begin
            n_fail++;
            $display("FAIL loa_r: got %h need 01FF", obs_r);
        end
        n_checks++;
        if (obs_rx !== 16'h020F) begin
            n_fail++;
            $display("FAIL loa_exact_r: got %h need 020F", obs_rx);
        end
`ifdef APPROX_MULT_ERR_MON_EN
        n_checks++;
        if (obs_err !== 16'h0010) begin
            n_fail++;
            $display("FAIL loa_err: got %h need 0010", obs_err);
        end
        n_checks++;
        if (err_cnt !== cnt0 + 16'd1) begin
            n_fail++;
            $display("FAIL loa_errcnt: got %h need %h", err_cnt, cnt0 + 16'd1);
        end
`endif
    endtask

    task automatic test_trunc();
        logic [7:0]  modes[3] = '{8'h03, 8'h01, 8'h00};
        logic [15:0] need[3]  = '{16'h0030, 16'h0030, 16'h0031};
        for (int i = 0; i < 3; i++) begin
            run_beat(8'h07, 8'h07, modes[i]);
            n_checks++;
            if (obs_r !== need[i]) begin
                n_fail++;
                $display("FAIL trunc_mode%h: got %h need %h", modes[i], obs_r, need[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got[$];
        int  sent = 0, stall = 0, stall_bad = 0;
        bit  seen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            in_valid = (sent < 4);
            a = 8'(sent + 1); b = 8'h10; mode = 8'h00;
            if (out_valid && !seen) begin seen = 1; stall = 5; end
            out_ready = (stall == 0);
            @(negedge clk);
            if (stall > 0) begin
                if (in_ready !== 1'b0 || r !== 16'h0010 || out_valid !== 1'b1) stall_bad++;
                stall--;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got.push_back(r);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (!seen || stall_bad != 0) begin
            n_fail++;
            $display("FAIL bp_stall: seen=%0d bad_stall_cycles=%0d need 1/0", seen, stall_bad);
        end
        n_checks++;
        if (got.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results need 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== 16'((i + 1) * 16)) begin
                n_fail++;
                $display("FAIL bp_order%0d: got %h need %h", i, got[i], 16'((i + 1) * 16));
            end
        end
    endtask

    task automatic test_reset_mid();
        int leaked = 0;
        out_ready = 1'b1; mode = 8'h00; b = 8'h22;
        in_valid = 1'b1; a = 8'h11;
        @(posedge clk); #1 a = 8'h33;
        @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || r !== '0) begin
            n_fail++;
            $display("FAIL rstmid_clear: out_valid=%b r=%h need 0/0000", out_valid, r);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) leaked++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (leaked != 0) begin
            n_fail++;
            $display("FAIL rstmid_leak: got %0d stale results need 0", leaked);
        end
        run_beat(8'hA5, 8'h3C, 8'h00);
        n_checks++;
        if (obs_lat !== 3 || obs_r !== 16'(ref_mult(8'hA5, 8'h3C, 0, 6))) begin
            n_fail++;
            $display("FAIL rstmid_next: lat=%0d r=%h need 3/%h", obs_lat, obs_r,
                     16'(ref_mult(8'hA5, 8'h3C, 0, 6)));
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$], expx_q[$];
        logic [15:0] e, ex;
        int bad_ready = 0, bad_r = 0, cmp = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc < 390) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            a = 8'($urandom); b = 8'($urandom); mode = 8'($urandom);
            @(negedge clk);
            if (in_ready !== (!out_valid || out_ready)) bad_ready++;
            if (in_valid && in_ready) begin
                exp_q.push_back(16'(ref_mult(a, b, mode, 6)));
                expx_q.push_back(16'(ref_mult(a, b, mode, 0)));
            end
            if (out_valid && out_ready) begin
                cmp++;
                if (exp_q.size() == 0) bad_r++;
                else begin
                    e = exp_q.pop_front();
                    ex = expx_q.pop_front();
                    if (r !== e || r_x !== ex) begin
                        bad_r++;
                        if (bad_r <= 4)
                            $display("FAIL rand_r: got %h/%h need %h/%h", r, r_x, e, ex);
                    end
                end
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL rand_in_ready: %0d cycles with wrong in_ready", bad_ready);
        end
        n_checks++;
        if (bad_r != 0 || cmp == 0) begin
            n_fail++;
            $display("FAIL rand_results: %0d bad of %0d compared, need 0 bad", bad_r, cmp);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: %0d results missing, need 0", exp_q.size());
        end
    endtask

`ifdef APPROX_MULT_ERR_MON_EN
    task automatic test_saturation();
        out_ready = 1'b1; in_valid = 1'b1; a = 8'h1F; b = 8'h11; mode = 8'h00;
        repeat (65540) @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (err_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_errcnt: got %h need FFFF", err_cnt);
        end
        n_checks++;
        if (err_cnt_x !== 16'h0000) begin
            n_fail++;
            $display("FAIL exact_errcnt: got %h need 0000", err_cnt_x);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_exact();
        test_loa();
        test_trunc();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef APPROX_MULT_ERR_MON_EN
        test_saturation();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
- Parametrised, pipelined W x W unsigned approximate multiplier; next generation of the fixed 8x8 quadrant multiplier.
- Splits operands into four H x H quadrant sub-products (H = W/2), each with run-time selectable truncation. Recombines them with a lower-part-OR approximate adder.
- Three register stages with valid/ready handshakes on both sides. Sits between operand sources and the accuracy-evaluation datapath.

Parameters:
W, 8, operand width; even, >= 4; H = W/2
TRUNC_STEP, 1, result bits cleared per mode step in a quadrant sub-product
LOA_BITS, 6, low bits of the final sum computed by OR (no carry); 0 = exact adder; range 0..2W-1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand/mode beat valid
in_ready  out  1  block can accept a beat this cycle
a  in  W  operand A (unsigned)
b  in  W  operand B (unsigned)
mode  in  8  per-quadrant approximation mode: [1:0] LL = a_lo*b_lo, [3:2] LH = a_lo*b_hi, [5:4] HL = a_hi*b_lo, [7:6] HH = a_hi*b_hi
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
r  out  2W  approximate product

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0; r = 0; all data registers = 0. in_ready = 1 in the cycle after reset deasserts. Reset mid-operation discards every in-flight beat, and no result is emitted for those beats.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages load only when adv = 1. Bubbles are not collapsed.
- Transfer: an input beat is accepted when in_valid && in_ready. An output beat completes when out_valid && out_ready.
- S1 (capture): registers a, b, mode and valid bit.
- S2 (quadrant products): computes the four sub-products as W-bit exact products.
  - Each sub-product has its low min(TRUNC_STEP*m, W) bits cleared, where m = that quadrant's 2-bit mode. m = 0 is exact.
  - Sub-products are registered together with the valid bit.
- S3 (recombine):
  - Contributions: C0 = LL, C1 = LH << H, C2 = HL << H, C3 = HH << W, each 2W bits.
  - Low part: low LOA_BITS bits = C0 | C1 | C2 | C3, bitwise OR over the low LOA_BITS bits.
  - High part: upper bits = sum of (Ci >> LOA_BITS), truncated to 2W - LOA_BITS bits. No carry from the low part.
  - Result registered into r; out_valid is set from the stage valid bit.
- Latency: 3 cycles from accept to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, every stage holds, r is stable, and in_ready = 0.
- Simultaneous accept and output in one cycle is legal; the pipeline shifts by one.
- Values are never negative, so r <= exact product always holds.
- mode is sampled with its operands, so a per-beat mode change takes effect only for that beat.

Optional Feature:
- Macro: APPROX_MULT_ERR_MON_EN.
- With the macro defined:
  - Extra ports err (out, 2W) and err_cnt (out, 16).
  - An exact product is pipelined alongside the datapath. err = exact - r, valid with out_valid.
  - err_cnt increments once per completed output beat with err != 0 and saturates at 0xFFFF. Synchronous reset clears it to 0.
- Without the macro: these ports and the shadow logic do not exist, and datapath timing is unchanged.

Test Plan:
1. Exact path (LOA_BITS = 0 build, mode = 0x00): a = 0xFF, b = 0xFF -> r = 0xFE01, 3 cycles after accept.
2. LOA error (defaults, mode = 0x00): a = 0x1F, b = 0x11 -> r = 0x01FF (exact 0x020F). With APPROX_MULT_ERR_MON_EN: err = 0x10 and err_cnt 0 -> 1.
3. Truncation (defaults): a = 0x07, b = 0x07, mode = 0x03 -> r = 0x30. mode = 0x01 -> 0x30. mode = 0x00 -> 0x31.
4. Streaming plus backpressure:
   - Stimulus: 4 back-to-back beats (a = 1,2,3,4; b = 0x10; mode = 0). Hold out_ready = 0 for 5 cycles once the first result appears.
   - Required: in_ready = 0 while stalled; r holds 0x10. Release gives 0x10, 0x20, 0x30, 0x40 in order with none lost or duplicated.
5. Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid = 0 and r = 0 afterwards; neither beat emerges; the next accepted beat produces a correct result at latency 3.
6. Counter saturation (macro on): preload via 65 540 error-producing beats -> err_cnt stops at 0xFFFF.
